sram_cache_banked: RTL and testbench
====================================

# sram_cache_banked

Banked single-port SRAM for cache data and tag arrays. The word space is split across NUM_BANKS interleaved banks, and only the addressed bank is enabled on each access. The block adds a req/gnt handshake, a read-valid strobe with latency 1 or 2, and an optional zero-initialisation sweep after reset. It sits between the cache controllers and the per-bank SRAM macros, so controllers no longer track read latency or memory init themselves.

## Interface
- DATA_WIDTH, 64, data bits per word
- USER_WIDTH, 1, user/sideband bits per word
- USER_EN, 0, store and return user bits when 1
- NUM_WORDS, 1024, total words; power of two, multiple of NUM_BANKS
- NUM_BANKS, 2, bank count; power of two, 1..16
- OUT_REGS, 0, 1 adds an output register stage (read latency 2)
- INIT_ON_RESET, 1, zero-fill all words after reset before granting
- TECHNO_CUT, 0, forwarded to each bank macro
- SIM_INIT, "none", forwarded to each bank macro
---
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- req_i  in  1  access request
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  $clog2(NUM_WORDS)  word address
- wdata_i  in  DATA_WIDTH  write data
- wuser_i  in  USER_WIDTH  write user bits
- be_i  in  (DATA_WIDTH+7)/8  byte enables for writes
- rvalid_o  out  1  read data valid
- rdata_o  out  DATA_WIDTH  read data
- ruser_o  out  USER_WIDTH  read user bits; 0 when USER_EN=0
- init_done_o  out  1  init sweep finished; block is accepting requests

## Operation
- Address split: bank = addr_i[BANK_BITS-1:0]; row = addr_i[AW-1:BANK_BITS].
  - ROWS = NUM_WORDS/NUM_BANKS.
  - BANK_BITS = $clog2(NUM_BANKS); when NUM_BANKS=1, BANK_BITS=0 and bank is always 0.
- FSM states: INIT, READY.
  - Reset enters INIT with row counter 0.
  - With INIT_ON_RESET=0, INIT exits to READY on the first clock after reset deasserts, with no writes performed.
  - With INIT_ON_RESET=1, each INIT cycle writes zero data, zero user bits and all-ones byte enables to row counter in every bank in parallel, then increments the counter.
  - After row ROWS-1 is written, the FSM moves to READY.
- gnt_o = req_i && state==READY. Combinational; gnt_o does not depend on gnt_o.
- Accepted access: only the selected bank's req is driven; all other banks are idle.
- Accepted write: no response is produced.
- Accepted read:
  - bank index and a valid bit enter a pipeline of depth 1+OUT_REGS.
  - at the end of the pipeline, rdata_o/ruser_o are muxed from the recorded bank.
- rvalid_o is high for exactly one cycle per accepted read. rdata_o and ruser_o are 0 whenever rvalid_o=0.
- Reads and writes complete in acceptance order. A read of an address written in the previous cycle returns the new data.
- Bytes with be_i=0 are left unchanged in the addressed word.
- Requests in INIT are ignored and do not modify memory. Requesters hold req_i until gnt_o.

## Timing
- Values after reset: gnt_o=0, rvalid_o=0, rdata_o=0, ruser_o=0, init_done_o=0, state=INIT, counter=0.
- Reset asserted mid-operation:
  - all in-flight read valids clear immediately (asynchronously).
  - the sweep restarts from row 0.
  - memory contents are undefined until the sweep completes.
- Read accepted at edge T: rvalid_o rises in cycle T+1 (OUT_REGS=0) or T+2 (OUT_REGS=1).
- Throughput: one access per cycle, reads and writes mixed back-to-back with no bubbles.
- init_done_o:
  - rises exactly ROWS cycles after the first clock edge with rst_i low when INIT_ON_RESET=1.
  - rises 1 cycle after that edge when INIT_ON_RESET=0.
  - stays high until the next reset.
- Row counter width is $clog2(ROWS)+1 so reaching ROWS is detectable with no wrap.

## Structure
- Package sram_cache_pkg holds:
  - typedef enum logic {INIT, READY} sram_init_state_e
  - function bank_bits(n) returning max(1, $clog2(n)) for the storage width of the bank index register.
- Sub-module: one sram_cache instance per bank, generated with NUM_WORDS=ROWS and OUT_REGS passed through.
  - The instance's active-low reset is driven from !rst_i.
- The read pipeline, FSM and output mux live at top level.

## Test plan
- Init sweep:
  - Stimulus: NUM_WORDS=64, NUM_BANKS=4, INIT_ON_RESET=1; release reset; hold req_i=1.
  - Response: gnt_o=0 for 16 cycles; init_done_o rises on cycle 16; a read of addr 37 returns 0.
- Write/read per bank:
  - Stimulus: write 0xDEAD_BEEF_0000_000k to addr k for k=0..7, then read addr 0..7 back-to-back.
  - Response: 8 consecutive rvalid_o pulses with matching data, starting 1 cycle after the first read (2 with OUT_REGS=1).
- Byte enables:
  - Stimulus: write 0xFFFF_FFFF_FFFF_FFFF to addr 5, then write 0 with be_i=0x0F.
  - Response: a read of addr 5 returns 0xFFFF_FFFF_0000_0000.
- Read-after-write:
  - Stimulus: write addr 9 = 0x1234 at T; read addr 9 at T+1.
  - Response: rvalid_o carries 0x1234.
- Reset mid-stream:
  - Stimulus: assert rst_i for 1 cycle while 2 reads are in flight (OUT_REGS=1).
  - Response: rvalid_o drops immediately; no late pulses appear; the sweep restarts and init_done_o rises ROWS cycles after release.
- Bank isolation:
  - Stimulus: for every access, check the per-bank enables.
  - Response: exactly one bank is enabled per granted access; none are enabled when gnt_o=0 in READY.

Source files
------------

// File: rtl/sram_cache_pkg.sv
// Shared types and helpers for the banked cache SRAM.
//   sram_init_state_e : init-sweep FSM states (INIT, READY)
//   clog2_min1(n)     : $clog2(n), but never narrower than one bit
//   bank_bits(n)      : storage width of a bank index register for n banks
package sram_cache_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_init_state_e;

  // A 1-entry structure still needs a 1-bit register to hold its index.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bank_bits(input int n);
    return clog2_min1(n);
  endfunction

endpackage

// File: rtl/sram_cache.sv
// Single-port SRAM bank model with byte-enabled writes and an optional
// output register stage.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (output/read registers only)
//   req_i    : access enable
//   we_i     : 1 = write, 0 = read
//   addr_i   : word address within the bank
//   wdata_i  : write data
//   wuser_i  : write user/sideband bits (stored only when USER_EN != 0)
//   be_i     : byte enables for writes
//   rdata_o  : read data, 1 cycle after the read (2 with OUT_REGS=1)
//   ruser_o  : read user bits, 0 when USER_EN == 0
module sram_cache
  import sram_cache_pkg::*;
#(
  parameter int    DATA_WIDTH = 64,
  parameter int    USER_WIDTH = 1,
  parameter int    USER_EN    = 0,
  parameter int    NUM_WORDS  = 512,
  parameter int    OUT_REGS   = 0,
  parameter int    TECHNO_CUT = 0,
  parameter string SIM_INIT   = "none",
  localparam int   AW         = clog2_min1(NUM_WORDS),
  localparam int   BE_W       = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  input  logic [BE_W-1:0]       be_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o
);

  // A hard cut or a preset simulation image gives the read register a
  // defined reset value; the plain behavioural array leaves it free so the
  // read port maps onto block RAM.
  localparam bit RdClear = (TECHNO_CUT != 0) || (SIM_INIT != "none");

  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rdata_raw;
  logic [USER_WIDTH-1:0] ruser_raw;

  assign rd_en = req_i && !we_i;
  assign wr_en = req_i && we_i;

  // One array per byte lane so each byte enable maps to a lane write enable.
  // The top lane is narrower when DATA_WIDTH is not a multiple of 8.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    localparam int Lo = 8 * gi;
    localparam int Lw = (gi == BE_W - 1) ? (DATA_WIDTH - 8 * gi) : 8;

    logic [Lw-1:0] mem [NUM_WORDS];
    logic [Lw-1:0] rd_reg;

    always_ff @(posedge clk_i) begin
      if (wr_en && be_i[gi]) begin
        mem[addr_i] <= wdata_i[Lo +: Lw];
      end
    end

    if (RdClear) begin : g_rd_clr
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd_reg <= '0;
        end else if (rd_en) begin
          rd_reg <= mem[addr_i];
        end
      end
    end else begin : g_rd
      always_ff @(posedge clk_i) begin
        if (rd_en) begin
          rd_reg <= mem[addr_i];
        end
      end
    end

    assign rdata_raw[Lo +: Lw] = rd_reg;
  end

  if (USER_EN != 0) begin : g_user
    logic [USER_WIDTH-1:0] umem [NUM_WORDS];
    logic [USER_WIDTH-1:0] urd_reg;

    // User bits travel with the word on every write, independent of be_i.
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        umem[addr_i] <= wuser_i;
      end
      if (rd_en) begin
        urd_reg <= umem[addr_i];
      end
    end
    assign ruser_raw = urd_reg;
  end else begin : g_no_user
    assign ruser_raw = '0;
  end

  if (OUT_REGS != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] rdata_oreg;
    logic [USER_WIDTH-1:0] ruser_oreg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_oreg <= '0;
        ruser_oreg <= '0;
      end else begin
        rdata_oreg <= rdata_raw;
        ruser_oreg <= ruser_raw;
      end
    end
    assign rdata_o = rdata_oreg;
    assign ruser_o = ruser_oreg;
  end else begin : g_no_oreg
    assign rdata_o = rdata_raw;
    assign ruser_o = ruser_raw;
  end

  // Reset and user inputs go unused in some parameterisations.
  logic unused_inputs;
  assign unused_inputs = ^{rst_ni, wuser_i};

endmodule

// File: rtl/sram_cache_banked.sv
// Banked single-port SRAM for cache data/tag arrays. Words are interleaved
// across NUM_BANKS banks (bank = low address bits); only the addressed bank
// is enabled per access. Adds req/gnt, a read-valid strobe (latency
// 1 + OUT_REGS) and an optional zero-fill sweep after reset.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   req_i / gnt_o    : request / accepted this cycle (only in READY)
//   we_i             : 1 = write, 0 = read
//   addr_i           : word address
//   wdata_i, wuser_i : write data / user bits
//   be_i             : write byte enables
//   rvalid_o         : one-cycle pulse per accepted read
//   rdata_o, ruser_o : read data / user bits, 0 when rvalid_o = 0
//   init_done_o      : sweep finished, requests are accepted
module sram_cache_banked
  import sram_cache_pkg::*;
#(
  parameter int    DATA_WIDTH    = 64,
  parameter int    USER_WIDTH    = 1,
  parameter int    USER_EN       = 0,
  parameter int    NUM_WORDS     = 1024,
  parameter int    NUM_BANKS     = 2,
  parameter int    OUT_REGS      = 0,
  parameter int    INIT_ON_RESET = 1,
  parameter int    TECHNO_CUT    = 0,
  parameter string SIM_INIT      = "none",
  localparam int   AW            = $clog2(NUM_WORDS),
  localparam int   BE_W          = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  input  logic [BE_W-1:0]       be_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o,
  output logic                  init_done_o
);

  localparam int ROWS      = NUM_WORDS / NUM_BANKS;
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W    = bank_bits(NUM_BANKS);
  localparam int ROW_W     = AW - BANK_BITS;
  // One spare bit so the counter can represent ROWS without wrapping.
  localparam int CNT_W     = $clog2(ROWS) + 1;
  localparam int PIPE      = 1 + OUT_REGS;

  sram_init_state_e state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             init_wr;

  logic [BANK_W-1:0] bank_sel;
  logic [ROW_W-1:0]  row_sel;
  logic [NUM_BANKS-1:0] bank_req;

  logic [ROW_W-1:0]      mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [USER_WIDTH-1:0] mem_wuser;
  logic [BE_W-1:0]       mem_be;
  logic                  rst_n;

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [USER_WIDTH-1:0] bank_ruser [NUM_BANKS];

  logic [PIPE-1:0]   vld_reg;
  logic [BANK_W-1:0] bank_pipe_reg [PIPE];
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic [USER_WIDTH-1:0] ruser_mux;

  // Address split: low bits pick the bank, the rest pick the row.
  if (BANK_BITS > 0) begin : g_split
    assign bank_sel = addr_i[BANK_BITS-1:0];
    assign row_sel  = addr_i[AW-1:BANK_BITS];
  end else begin : g_single
    assign bank_sel = '0;
    assign row_sel  = addr_i;
  end

  // Init / ready FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_wr    = 1'b0;
    case (state_reg)
      INIT: begin
        if (INIT_ON_RESET != 0) begin
          // Zero one row in every bank per cycle.
          init_wr  = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(ROWS - 1)) begin
            state_next = READY;
          end
        end else begin
          state_next = READY;
        end
      end
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  assign gnt_o       = req_i && (state_reg == READY);
  assign init_done_o = (state_reg == READY);

  // Shared bank write/read port: the sweep overrides the requester.
  assign mem_we    = init_wr || we_i;
  assign mem_addr  = init_wr ? cnt_reg[ROW_W-1:0] : row_sel;
  assign mem_wdata = init_wr ? '0 : wdata_i;
  assign mem_wuser = init_wr ? '0 : wuser_i;
  assign mem_be    = init_wr ? '1 : be_i;
  assign rst_n     = !rst_i;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_req[gi] = init_wr || (gnt_o && (bank_sel == BANK_W'(gi)));

    sram_cache #(
      .DATA_WIDTH (DATA_WIDTH),
      .USER_WIDTH (USER_WIDTH),
      .USER_EN    (USER_EN),
      .NUM_WORDS  (ROWS),
      .OUT_REGS   (OUT_REGS),
      .TECHNO_CUT (TECHNO_CUT),
      .SIM_INIT   (SIM_INIT)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_n),
      .req_i   (bank_req[gi]),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .wuser_i (mem_wuser),
      .be_i    (mem_be),
      .rdata_o (bank_rdata[gi]),
      .ruser_o (bank_ruser[gi])
    );
  end

  // Read tracking pipeline: matches the bank read latency so the output mux
  // knows which bank's data to present when the strobe reaches the end.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_reg <= '0;
      for (int i = 0; i < PIPE; i++) begin
        bank_pipe_reg[i] <= '0;
      end
    end else begin
      vld_reg[0]       <= gnt_o && !we_i;
      bank_pipe_reg[0] <= bank_sel;
      for (int i = 1; i < PIPE; i++) begin
        vld_reg[i]       <= vld_reg[i-1];
        bank_pipe_reg[i] <= bank_pipe_reg[i-1];
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    ruser_mux = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_pipe_reg[PIPE-1] == BANK_W'(i)) begin
        rdata_mux = bank_rdata[i];
        ruser_mux = bank_ruser[i];
      end
    end
  end

  assign rvalid_o = vld_reg[PIPE-1];
  assign rdata_o  = rvalid_o ? rdata_mux : '0;
  assign ruser_o  = (rvalid_o && (USER_EN != 0)) ? ruser_mux : '0;

  logic unused_cnt_msb;
  assign unused_cnt_msb = cnt_reg[CNT_W-1];

endmodule

// File: tb/tb_sram_cache_banked.sv
// Self-checking bench for sram_cache_banked (64 words, 4 banks, output
// register stage, user bits enabled). A behavioural model holds memory as a
// flat word array, applies byte-enabled writes in acceptance order and
// schedules each accepted read to appear LAT cycles later.
module tb_sram_cache_banked;

  localparam int DW    = 64;
  localparam int UW    = 4;
  localparam int NW    = 64;
  localparam int NB    = 4;
  localparam int OREGS = 1;
  localparam int ROWS  = NW / NB;
  localparam int LAT   = 1 + OREGS;

  logic          clk     = 1'b0;
  logic          rst_i   = 1'b0;
  logic          req_i   = 1'b0;
  logic          we_i    = 1'b0;
  logic [5:0]    addr_i  = '0;
  logic [DW-1:0] wdata_i = '0;
  logic [UW-1:0] wuser_i = '0;
  logic [7:0]    be_i    = '0;
  logic          gnt_o;
  logic          rvalid_o;
  logic [DW-1:0] rdata_o;
  logic [UW-1:0] ruser_o;
  logic          init_done_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc     = 0;
  int rel_cnt = 0;

  logic [DW-1:0] mem_m  [NW];
  logic [UW-1:0] user_m [NW];

  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
  } rd_t;
  rd_t exp_q[$];

  sram_cache_banked #(
    .DATA_WIDTH    (DW),
    .USER_WIDTH    (UW),
    .USER_EN       (1),
    .NUM_WORDS     (NW),
    .NUM_BANKS     (NB),
    .OUT_REGS      (OREGS),
    .INIT_ON_RESET (1),
    .TECHNO_CUT    (0),
    .SIM_INIT      ("none")
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .wuser_i     (wuser_i),
    .be_i        (be_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .ruser_o     (ruser_o),
    .init_done_o (init_done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Clock edges seen with reset low since the last reset.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) rel_cnt <= 0;
    else       rel_cnt <= rel_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response check for the current cycle against the scheduled reads.
  task automatic check_resp();
    rd_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rvalid", rvalid_o, 1'b1);
      chk("rdata", rdata_o, e.d);
      chk("ruser", ruser_o, e.u);
      $display("cyc %0d read resp data %h user %h", cyc, rdata_o, ruser_o);
    end else begin
      chk("rvalid_idle", rvalid_o, 1'b0);
      chk("rdata_idle", rdata_o, '0);
      chk("ruser_idle", ruser_o, '0);
    end
  endtask

  // One clock cycle: check responses, drive a request, check handshake and
  // bank enables, update the model for an accepted access.
  task automatic step(input bit r, input bit rq, input bit w, input logic [5:0] a,
                      input logic [63:0] d, input logic [3:0] u, input logic [7:0] b,
                      output bit acc);
    bit   rdy;
    rd_t  e;
    logic [3:0] exp_en;
    @(negedge clk);
    check_resp();
    rst_i   = r;
    req_i   = rq;
    we_i    = w;
    addr_i  = a;
    wdata_i = d;
    wuser_i = u;
    be_i    = b;
    #1;
    rdy = !r && (rel_cnt >= ROWS);
    acc = rq && rdy;
    if (r) begin
      exp_q.delete();
      foreach (mem_m[i]) begin
        mem_m[i]  = '0;
        user_m[i] = '0;
      end
      chk("rst_rvalid", rvalid_o, 1'b0);
      chk("rst_rdata", rdata_o, '0);
    end else begin
      if (!rdy)    exp_en = 4'hF;
      else if (rq) exp_en = 4'(1 << (a % NB));
      else         exp_en = 4'h0;
      chk("bank_en", dut.bank_req, exp_en);
    end
    chk("gnt", gnt_o, acc);
    chk("init_done", init_done_o, rdy);
    if (acc) begin
      if (w) begin
        for (int i = 0; i < 8; i++) begin
          if (b[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
        end
        user_m[a] = u;
        $display("cyc %0d write addr %0d data %h be %h", cyc, a, d, b);
      end else begin
        e.due = cyc + LAT;
        e.d   = mem_m[a];
        e.u   = user_m[a];
        exp_q.push_back(e);
        $display("cyc %0d read addr %0d", cyc, a);
      end
    end
  endtask

  initial begin
    bit acc;
    foreach (mem_m[i]) begin
      mem_m[i]  = '0;
      user_m[i] = '0;
    end

    // Reset values, with a request already pending.
    #2;
    rst_i  = 1'b1;
    req_i  = 1'b1;
    addr_i = 6'd37;
    #1;
    chk("reset_gnt", gnt_o, 1'b0);
    chk("reset_rvalid", rvalid_o, 1'b0);
    chk("reset_rdata", rdata_o, '0);
    chk("reset_ruser", ruser_o, '0);
    chk("reset_init_done", init_done_o, 1'b0);
    step(1, 1, 0, 6'd37, '0, '0, '0, acc);
    step(1, 1, 0, 6'd37, '0, '0, '0, acc);

    // Init sweep: hold a read of 37 until granted.
    acc = 1'b0;
    for (int i = 0; i < ROWS + 4 && !acc; i++) begin
      step(0, 1, 0, 6'd37, '0, '0, '0, acc);
    end

    // Write/read per bank, back-to-back.
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 1, 6'(k), 64'hDEAD_BEEF_0000_0000 | 64'(k), 4'(k), 8'hFF, acc);
    end
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, 6'(k), '0, '0, '0, acc);
    end

    // Byte enables.
    step(0, 1, 1, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 8'hFF, acc);
    step(0, 1, 1, 6'd5, 64'h0, 4'h2, 8'h0F, acc);
    step(0, 1, 0, 6'd5, '0, '0, '0, acc);

    // Read-after-write in the next cycle.
    step(0, 1, 1, 6'd9, 64'h1234, 4'h3, 8'hFF, acc);
    step(0, 1, 0, 6'd9, '0, '0, '0, acc);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           6'($urandom_range(0, NW - 1)), {$urandom, $urandom},
           4'($urandom), 8'($urandom), acc);
    end

    // Reset with two reads in flight.
    step(0, 1, 0, 6'd12, '0, '0, '0, acc);
    step(0, 1, 0, 6'd13, '0, '0, '0, acc);
    step(1, 0, 0, '0, '0, '0, '0, acc);
    for (int i = 0; i < ROWS + 3; i++) begin
      step(0, 0, 0, '0, '0, '0, '0, acc);
    end

    // Contents after the re-sweep, then more random traffic.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 6'($urandom_range(0, NW - 1)), '0, '0, '0, acc);
    end
    for (int i = 0; i < 60; i++) begin
      step(0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
           6'($urandom_range(0, NW - 1)), {$urandom, $urandom},
           4'($urandom), 8'($urandom), acc);
    end

    // Drain outstanding reads.
    for (int i = 0; i < LAT + 2; i++) begin
      step(0, 0, 0, '0, '0, '0, '0, acc);
    end
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
